// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the data memory, with an atomic
// read/write lock that a single port may hold until its conditional store or a timeout.
module dmem_arbiter #(
    parameter int unsigned LOCK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic        p0_atomic,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_ack,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic        p1_atomic,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ack,
    output logic [31:0] p1_rdata,
    output logic        mem_we,
    output logic        mem_atomic,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        lock_active,
    output logic        lock_owner,
    output logic        lock_timeout
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic [7:0] LastCnt = 8'(LOCK_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        sel_q, sel_d;
    logic        last_grant_q, last_grant_d;
    logic        cmd_we_q, cmd_we_d;
    logic        cmd_atomic_q, cmd_atomic_d;
    logic [31:0] cmd_addr_q, cmd_addr_d;
    logic [31:0] cmd_wdata_q, cmd_wdata_d;
    logic [31:0] p0_rdata_q, p0_rdata_d;
    logic [31:0] p1_rdata_q, p1_rdata_d;
    logic        lock_active_q, lock_active_d;
    logic        lock_owner_q, lock_owner_d;
    logic [7:0]  lock_cnt_q, lock_cnt_d;
    logic        lock_timeout_q, lock_timeout_d;

    logic        elig0, elig1, grant, aw_ok;
    logic [31:0] result;

    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        last_grant_d   = last_grant_q;
        cmd_we_d       = cmd_we_q;
        cmd_atomic_d   = cmd_atomic_q;
        cmd_addr_d     = cmd_addr_q;
        cmd_wdata_d    = cmd_wdata_q;
        p0_rdata_d     = p0_rdata_q;
        p1_rdata_d     = p1_rdata_q;
        lock_active_d  = lock_active_q;
        lock_owner_d   = lock_owner_q;
        lock_cnt_d     = lock_cnt_q;
        lock_timeout_d = 1'b0;
        mem_we         = 1'b0;
        mem_atomic     = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        p0_ack         = 1'b0;
        p1_ack         = 1'b0;
        result         = '0;

        // While locked only the owner may be granted.
        elig0 = p0_req && (!lock_active_q || !lock_owner_q);
        elig1 = p1_req && (!lock_active_q || lock_owner_q);
        grant = (elig0 && elig1) ? !last_grant_q : elig1;
        aw_ok = lock_active_q && (lock_owner_q == sel_q);

        unique case (state_q)
            StIdle: begin
                if (elig0 || elig1) begin
                    sel_d        = grant;
                    last_grant_d = grant;
                    cmd_we_d     = grant ? p1_we : p0_we;
                    cmd_atomic_d = grant ? p1_atomic : p0_atomic;
                    cmd_addr_d   = grant ? p1_addr : p0_addr;
                    cmd_wdata_d  = grant ? p1_wdata : p0_wdata;
                    state_d      = StAccess;
                    if (lock_active_q && (grant == lock_owner_q)) begin
                        lock_cnt_d = '0;
                    end
                end else if (lock_active_q) begin
                    if (lock_cnt_q == LastCnt) begin
                        lock_active_d  = 1'b0;
                        lock_timeout_d = 1'b1;
                        lock_cnt_d     = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + 8'd1;
                    end
                end
            end
            StAccess: begin
                mem_addr   = cmd_addr_q;
                mem_wdata  = cmd_wdata_q;
                mem_atomic = cmd_atomic_q;
                mem_we     = cmd_we_q && (!cmd_atomic_q || aw_ok);
                result     = cmd_we_q ? {31'b0, aw_ok} : mem_rdata;
                // Plain writes leave the port's rdata untouched.
                if (!cmd_we_q || cmd_atomic_q) begin
                    if (sel_q) begin
                        p1_rdata_d = result;
                    end else begin
                        p0_rdata_d = result;
                    end
                end
                if (cmd_atomic_q && !cmd_we_q) begin
                    lock_active_d = 1'b1;
                    lock_owner_d  = sel_q;
                    lock_cnt_d    = '0;
                end else if (cmd_atomic_q && aw_ok) begin
                    lock_active_d = 1'b0;
                end
                state_d = StResp;
            end
            StResp: begin
                p0_ack  = !sel_q;
                p1_ack  = sel_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (!lock_active_d) begin
            lock_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            sel_q          <= 1'b0;
            last_grant_q   <= 1'b1;
            cmd_we_q       <= 1'b0;
            cmd_atomic_q   <= 1'b0;
            cmd_addr_q     <= '0;
            cmd_wdata_q    <= '0;
            p0_rdata_q     <= '0;
            p1_rdata_q     <= '0;
            lock_active_q  <= 1'b0;
            lock_owner_q   <= 1'b0;
            lock_cnt_q     <= '0;
            lock_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            last_grant_q   <= last_grant_d;
            cmd_we_q       <= cmd_we_d;
            cmd_atomic_q   <= cmd_atomic_d;
            cmd_addr_q     <= cmd_addr_d;
            cmd_wdata_q    <= cmd_wdata_d;
            p0_rdata_q     <= p0_rdata_d;
            p1_rdata_q     <= p1_rdata_d;
            lock_active_q  <= lock_active_d;
            lock_owner_q   <= lock_owner_d;
            lock_cnt_q     <= lock_cnt_d;
            lock_timeout_q <= lock_timeout_d;
        end
    end

    assign p0_rdata     = p0_rdata_q;
    assign p1_rdata     = p1_rdata_q;
    assign lock_active  = lock_active_q;
    assign lock_owner   = lock_owner_q;
    assign lock_timeout = lock_timeout_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a small word memory model, expected read data
// queued per port at issue time and compared when the port's ack arrives.
module tb_dmem_arbiter;

    localparam int unsigned LockTimeout = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tb_init;
    logic        p0_req, p0_we, p0_atomic, p0_ack;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_req, p1_we, p1_atomic, p1_ack;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic        mem_we, mem_atomic, lock_active, lock_owner, lock_timeout;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [256];
    int          we_count;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    always #5 clk = ~clk;

    dmem_arbiter #(.LOCK_TIMEOUT(LockTimeout)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .p0_req      (p0_req),
        .p0_we       (p0_we),
        .p0_atomic   (p0_atomic),
        .p0_addr     (p0_addr),
        .p0_wdata    (p0_wdata),
        .p0_ack      (p0_ack),
        .p0_rdata    (p0_rdata),
        .p1_req      (p1_req),
        .p1_we       (p1_we),
        .p1_atomic   (p1_atomic),
        .p1_addr     (p1_addr),
        .p1_wdata    (p1_wdata),
        .p1_ack      (p1_ack),
        .p1_rdata    (p1_rdata),
        .mem_we      (mem_we),
        .mem_atomic  (mem_atomic),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .lock_active (lock_active),
        .lock_owner  (lock_owner),
        .lock_timeout(lock_timeout)
    );

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + 32'(i);
            we_count <= 0;
        end else if (mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
            we_count           <= we_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input bit port, input bit we, input bit atomic,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp);
        if (port) begin
            p1_req = 1'b1; p1_we = we; p1_atomic = atomic; p1_addr = addr; p1_wdata = wdata;
            q1.push_back(exp);
        end else begin
            p0_req = 1'b1; p0_we = we; p0_atomic = atomic; p0_addr = addr; p0_wdata = wdata;
            q0.push_back(exp);
        end
    endtask

    // Returns on the negedge of the ack (RESP cycle), where req is dropped.
    task automatic wait_ack(input bit port, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (port ? p1_ack : p0_ack) seen = 1'b1;
        end
        chk({tag, "_ack"}, 32'(seen), 32'd1);
        if (port) begin
            chk(tag, p1_rdata, q1.pop_front());
            p1_req = 1'b0;
        end else begin
            chk(tag, p0_rdata, q0.pop_front());
            p0_req = 1'b0;
        end
    endtask

    initial begin
        int acks, last, pulses, at, we0, p1_acks;
        bit seen;
        rst_n = 1'b0; tb_init = 1'b1;
        p0_req = 0; p0_we = 0; p0_atomic = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_atomic = 0; p1_addr = '0; p1_wdata = '0;
        repeat (3) @(negedge clk);
        tb_init = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        chk("rst_flags", {25'b0, p0_ack, p1_ack, mem_we, mem_atomic, lock_active, lock_owner,
            lock_timeout}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_p0_rdata", p0_rdata, 32'd0);
        chk("rst_p1_rdata", p1_rdata, 32'd0);

        // Round-robin with both ports requesting continuously.
        issue(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hA000_0004);
        issue(1'b1, 1'b0, 1'b0, 32'h14, 32'h0, 32'hA000_0005);
        q0.push_back(32'hA000_0004);
        q1.push_back(32'hA000_0005);
        acks = 0; last = 0;
        for (int c = 1; c <= 40 && acks < 4; c++) begin
            @(negedge clk);
            if (c == 1) chk("rr_first_addr", mem_addr, 32'h10);
            if (p0_ack || p1_ack) begin
                if (acks == 0) chk("rr_latency", 32'(c), 32'd2);
                else chk("rr_gap", 32'(c - last), 32'd3);
                chk("rr_port", 32'(p1_ack), 32'(acks % 2));
                if (p1_ack) chk("rr_p1_rdata", p1_rdata, q1.pop_front());
                else chk("rr_p0_rdata", p0_rdata, q0.pop_front());
                last = c;
                acks++;
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        chk("rr_count", 32'(acks), 32'd4);

        // Lock held by p0 stalls p1 until the conditional store completes.
        issue(1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 32'hA000_0008);
        wait_ack(1'b0, "lk_aread");
        chk("lk_active", 32'(lock_active), 32'd1);
        chk("lk_owner", 32'(lock_owner), 32'd0);
        issue(1'b1, 1'b1, 1'b0, 32'h20, 32'h5, 32'hA000_0005);
        p1_acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (p1_ack) p1_acks++;
        end
        chk("lk_stall", 32'(p1_acks), 32'd0);
        issue(1'b0, 1'b1, 1'b1, 32'h20, 32'h7, 32'd1);
        wait_ack(1'b0, "lk_awrite");
        chk("lk_mem7", mem[8], 32'h7);
        chk("lk_released", 32'(lock_active), 32'd0);
        wait_ack(1'b1, "lk_p1write");
        chk("lk_mem5", mem[8], 32'h5);

        // Lock timeout, then the stale conditional store fails.
        issue(1'b0, 1'b0, 1'b1, 32'h30, 32'h0, 32'hA000_000C);
        wait_ack(1'b0, "to_aread");
        pulses = 0; at = 0;
        for (int c = 1; c <= int'(LockTimeout) + 10; c++) begin
            @(negedge clk);
            if (lock_timeout) begin
                pulses++;
                at = c;
            end
        end
        chk("to_pulses", 32'(pulses), 32'd1);
        chk("to_cycle", 32'(at), 32'(LockTimeout + 1));
        chk("to_unlocked", 32'(lock_active), 32'd0);
        we0 = we_count;
        issue(1'b0, 1'b1, 1'b1, 32'h30, 32'h99, 32'd0);
        wait_ack(1'b0, "to_awrite");
        chk("to_no_we", 32'(we_count), 32'(we0));
        chk("to_mem", mem[12], 32'hA000_000C);

        // Conditional store with no lock held.
        we0 = we_count;
        issue(1'b1, 1'b1, 1'b1, 32'h40, 32'h55, 32'd0);
        wait_ack(1'b1, "ul_awrite");
        chk("ul_no_we", 32'(we_count), 32'(we0));
        chk("ul_mem", mem[16], 32'hA000_0010);

        // Reset during the ACCESS cycle of a write.
        issue(1'b0, 1'b0, 1'b1, 32'h50, 32'h0, 32'hA000_0014);
        wait_ack(1'b0, "rm_aread");
        p0_req = 1'b1; p0_we = 1'b1; p0_atomic = 1'b0; p0_addr = 32'h54; p0_wdata = 32'h1234;
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            if (mem_we) seen = 1'b1;
        end
        chk("rm_in_access", 32'(seen), 32'd1);
        rst_n  = 1'b0;
        p0_req = 1'b0;
        #1;
        chk("rm_we_off", 32'(mem_we), 32'd0);
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (p0_ack || p1_ack) acks++;
        end
        chk("rm_no_ack", 32'(acks), 32'd0);
        chk("rm_lock_clr", 32'(lock_active), 32'd0);
        chk("rm_no_write", mem[21], 32'hA000_0015);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rm_rdata_clr", p0_rdata, 32'd0);
        issue(1'b0, 1'b0, 1'b0, 32'h54, 32'h0, 32'hA000_0015);
        wait_ack(1'b0, "rm_resume");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
